// File: rtl/sr_bank_driver.sv
// Converts a D-style target word into set/reset pulses for an external SR flip-flop bank.
// Optional readback compare of q_fb against the shadow state: define SR_BANK_READBACK_CHECK_EN.
module sr_bank_driver #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic             cnt_clr,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow_q,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic             err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] lat_d;
  logic [SCW-1:0]   scnt;
  logic [WIDTH-1:0] s_nxt, r_nxt;

  assign s_nxt    = in_d & ~shadow_q;
  assign r_nxt    = ~in_d & shadow_q;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [WIDTH-1:0] bits);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt};
    for (int i = 0; i < WIDTH; i++) sum = sum + (CNT_W+1)'(bits[i]);
    return (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // s and r are disjoint by construction, so no bit ever sees s=r=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_d    <= '0;
      scnt     <= '0;
      s_out    <= '0;
      r_out    <= '0;
      shadow_q <= '0;
    end else begin
      s_out <= '0;
      r_out <= '0;
      case (state)
        IDLE: if (in_valid) begin
          lat_d <= in_d;
          if (|(s_nxt | r_nxt)) begin
            state <= DRIVE;
            s_out <= s_nxt;
            r_out <= r_nxt;
          end else begin
            state <= DONE;
          end
        end
        DRIVE: begin
          shadow_q <= lat_d;
          scnt     <= '0;
          state    <= (SETTLE_CYC > 0) ? SETTLE : DONE;
        end
        SETTLE: begin
          if (scnt == SETTLE_LAST) state <= DONE;
          else                     scnt  <= scnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear coinciding with a DRIVE increment wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_cnt <= '0;
      rst_cnt <= '0;
    end else if (cnt_clr) begin
      set_cnt <= '0;
      rst_cnt <= '0;
    end else if (state == DRIVE) begin
      set_cnt <= sat_add(set_cnt, s_out);
      rst_cnt <= sat_add(rst_cnt, r_out);
    end
  end

`ifdef SR_BANK_READBACK_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err <= 1'b0;
    else if (cnt_clr)                          err <= 1'b0;
    else if (state == DONE && q_fb != shadow_q) err <= 1'b1;
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver (WIDTH=4, SETTLE_CYC=1, CNT_W=8).
module tb_sr_bank_driver;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, cnt_clr, busy, done, err;
  logic [3:0] in_d, q_fb, s_out, r_out, shadow_q;
  logic [7:0] set_cnt, rst_cnt;
  int tests = 0, fails = 0;

`ifdef SR_BANK_READBACK_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  sr_bank_driver #(.WIDTH(4), .SETTLE_CYC(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .cnt_clr(cnt_clr), .q_fb(q_fb), .s_out(s_out), .r_out(r_out), .busy(busy),
    .done(done), .shadow_q(shadow_q), .set_cnt(set_cnt), .rst_cnt(rst_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] d);
    int k;
    in_valid = 1'b1;
    in_d     = d;
    step();
    in_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("req_done", {31'd0, done}, 32'd1);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_d = '0; cnt_clr = 1'b0; q_fb = '0;
    // 1. reset
    step(); step();
    chk("rst_s_out", s_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_shadow", shadow_q, 0);
    chk("rst_cnts", {set_cnt, rst_cnt}, 0);
    chk("rst_done_err", {done, err}, 0);

    // 2. 1010 from 0000
    in_valid = 1'b1; in_d = 4'b1010;
    step();
    in_valid = 1'b0;
    chk("w1_s_out", s_out, 4'b1010);
    chk("w1_r_out", r_out, 4'b0000);
    chk("w1_busy_rdy", {busy, in_ready}, 2'b10);
    chk("w1_done_n1", done, 0);
    step();
    chk("w1_settle_s", s_out, 0);
    chk("w1_done_n2", done, 0);
    chk("w1_shadow", shadow_q, 4'b1010);
    chk("w1_cnts", {set_cnt, rst_cnt}, {8'd2, 8'd0});
    step();
    chk("w1_done_n3", done, 1);
    step();
    chk("w1_idle", {done, in_ready, busy}, 3'b010);

    // 3. 0110 from 1010
    in_valid = 1'b1; in_d = 4'b0110;
    step();
    in_valid = 1'b0;
    chk("w2_s_out", s_out, 4'b0100);
    chk("w2_r_out", r_out, 4'b1000);
    step();
    chk("w2_shadow", shadow_q, 4'b0110);
    chk("w2_cnts", {set_cnt, rst_cnt}, {8'd3, 8'd1});
    step();
    chk("w2_done", done, 1);
    step();

    // 4. repeat 0110: no pulses, done at N+1
    in_valid = 1'b1; in_d = 4'b0110;
    step();
    in_valid = 1'b0;
    chk("w3_done_n1", done, 1);
    chk("w3_no_pulse", {s_out, r_out}, 0);
    step();
    chk("w3_idle", {done, in_ready}, 2'b01);
    chk("w3_cnts", {set_cnt, rst_cnt}, {8'd3, 8'd1});

    // 5. 1001, then 1111 held while busy, then reset during DRIVE
    in_valid = 1'b1; in_d = 4'b1001;
    step();
    in_d = 4'b1111;
    chk("w4_s_out", s_out, 4'b1001);
    chk("w4_r_out", r_out, 4'b0110);
    chk("w4_rdy_n1", in_ready, 0);
    step();
    chk("w4_rdy_n2", in_ready, 0);
    chk("w4_cnts", {set_cnt, rst_cnt}, {8'd5, 8'd3});
    step();
    chk("w4_done_rdy", {done, in_ready}, 2'b10);
    step();
    chk("w4_idle_rdy", {in_ready, s_out}, {1'b1, 4'b0000});
    chk("w4_shadow", shadow_q, 4'b1001);
    step();
    in_valid = 1'b0;
    chk("w5_s_out", s_out, 4'b0110);
    chk("w5_r_out", r_out, 4'b0000);
    #1 rst = 1'b1;
    #1;
    chk("arst_pulses", {s_out, r_out}, 0);
    chk("arst_shadow", shadow_q, 0);
    chk("arst_idle", {busy, in_ready}, 2'b01);
    chk("arst_cnts", {set_cnt, rst_cnt}, 0);
    step();
    rst = 1'b0;
    #1;

    // 6. readback check with q_fb stuck at 0
    q_fb = 4'b0000;
    do_req(4'b0001);
    chk("rb_err", err, ERR_EXP);
    chk("rb_set_cnt", set_cnt, 1);
    step(); step();
    chk("rb_err_sticky", err, ERR_EXP);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_cnts", {set_cnt, rst_cnt}, 0);
    chk("clr_shadow", shadow_q, 4'b0001);

    // clear coinciding with the DRIVE increment
    in_valid = 1'b1; in_d = 4'b0000;
    step();
    in_valid = 1'b0;
    chk("col_r_out", r_out, 4'b0001);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("col_cnts", {set_cnt, rst_cnt}, 0);
    chk("col_shadow", shadow_q, 0);
    step(); step();
    chk("col_idle", in_ready, 1);

    // saturation: 70 x (4 sets + 4 resets) exceeds 255
    for (int i = 0; i < 70; i++) begin
      do_req(4'b1111);
      do_req(4'b0000);
    end
    chk("sat_set_cnt", set_cnt, 8'd255);
    chk("sat_rst_cnt", rst_cnt, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
